// File: rtl/timer_mmio_arbiter.sv
// Two-master round-robin arbiter in front of the timer MMIO port.
// One transaction in flight; out-of-window addresses and read timeouts complete with err.
module timer_mmio_arbiter #(
   parameter logic [15:0] BASE_HI    = 16'h3FF5,
   parameter int          RD_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0,
   input  logic        req1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   input  logic        we0,
   input  logic        we1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] t_addr,
   output logic [31:0] t_wdata,
   output logic        t_wr,
   output logic        t_rd,
   input  logic        t_rd_valid,
   input  logic [31:0] t_rdata
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT_RD = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   localparam int               CNT_W   = (RD_TIMEOUT > 2) ? $clog2(RD_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RD_TIMEOUT - 1);

   logic [1:0]       state;
   logic             gid;
   logic             last_grant;
   logic             we_l;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       ack_r;
   logic [1:0]       err_r;
   logic [1:0][31:0] rdata_r;

   logic             g_id;
   logic [31:0]      g_addr;
   logic [31:0]      g_wdata;
   logic             g_we;
   logic             g_in_win;

   // Round-robin pick: on contention the requester not served last wins.
   always_comb begin
      g_id = 1'b0;
      if (req0 && req1)
         g_id = ~last_grant;
      else if (req1)
         g_id = 1'b1;
      g_addr   = g_id ? addr1  : addr0;
      g_wdata  = g_id ? wdata1 : wdata0;
      g_we     = g_id ? we1    : we0;
      g_in_win = (g_addr[31:16] == BASE_HI);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         gid        <= 1'b0;
         last_grant <= 1'b1;
         we_l       <= 1'b0;
         cnt        <= '0;
         ack_r      <= '0;
         err_r      <= '0;
         rdata_r    <= '0;
         t_addr     <= '0;
         t_wdata    <= '0;
         t_wr       <= 1'b0;
         t_rd       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req0 || req1) begin
                  gid        <= g_id;
                  last_grant <= g_id;
                  we_l       <= g_we;
                  if (g_in_win) begin
                     t_addr  <= g_addr;
                     t_wdata <= g_wdata;
                     t_wr    <= g_we;
                     t_rd    <= ~g_we;
                     state   <= S_ISSUE;
                  end else begin
                     ack_r[g_id]   <= 1'b1;
                     err_r[g_id]   <= 1'b1;
                     rdata_r[g_id] <= '0;
                     state         <= S_DONE;
                  end
               end
            end
            S_ISSUE: begin
               t_wr <= 1'b0;
               t_rd <= 1'b0;
               if (we_l) begin
                  ack_r[gid] <= 1'b1;
                  err_r[gid] <= 1'b0;
                  state      <= S_DONE;
               end else begin
                  cnt   <= '0;
                  state <= S_WAIT_RD;
               end
            end
            S_WAIT_RD: begin
               if (t_rd_valid) begin
                  rdata_r[gid] <= t_rdata;
                  ack_r[gid]   <= 1'b1;
                  err_r[gid]   <= 1'b0;
                  state        <= S_DONE;
               end else if (cnt == CNT_MAX) begin
                  rdata_r[gid] <= '0;
                  ack_r[gid]   <= 1'b1;
                  err_r[gid]   <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               // Requests are ignored here so a still-high req is not re-granted.
               ack_r <= '0;
               err_r <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign ack0   = ack_r[0];
   assign ack1   = ack_r[1];
   assign err0   = err_r[0];
   assign err1   = err_r[1];
   assign rdata0 = rdata_r[0];
   assign rdata1 = rdata_r[1];

endmodule

// File: tb/tb_timer_mmio_arbiter.sv
// Directed bench for timer_mmio_arbiter: writes, reads, contention, window filter,
// read timeout and mid-read reset, with hand-computed expectations.
module tb_timer_mmio_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0, req1 = 1'b0;
   logic [31:0] addr0 = '0, addr1 = '0;
   logic [31:0] wdata0 = '0, wdata1 = '0;
   logic        we0 = 1'b0, we1 = 1'b0;
   logic        ack0, ack1, err0, err1;
   logic [31:0] rdata0, rdata1;
   logic [31:0] t_addr, t_wdata;
   logic        t_wr, t_rd;
   logic        t_rd_valid = 1'b0;
   logic [31:0] t_rdata = '0;

   int checks = 0;
   int errors = 0;
   int excl_bad = 0;
   int acks_seen = 0;

   timer_mmio_arbiter #(.BASE_HI(16'h3FF5), .RD_TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .we0(we0), .we1(we1),
      .ack0(ack0), .ack1(ack1),
      .rdata0(rdata0), .rdata1(rdata1),
      .err0(err0), .err1(err1),
      .t_addr(t_addr), .t_wdata(t_wdata),
      .t_wr(t_wr), .t_rd(t_rd),
      .t_rd_valid(t_rd_valid), .t_rdata(t_rdata)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if ((t_wr && t_rd) || (ack0 && ack1))
         excl_bad = excl_bad + 1;
      if (ack0 || ack1)
         acks_seen = acks_seen + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   initial begin
      int acks_before;

      // Reset state
      tick();
      tick();
      chk("rst_ack0", 32'(ack0), 32'd0);
      chk("rst_ack1", 32'(ack1), 32'd0);
      chk("rst_err0", 32'(err0), 32'd0);
      chk("rst_strobes", 32'({t_wr, t_rd}), 32'd0);
      chk("rst_t_addr", t_addr, 32'd0);
      chk("rst_t_wdata", t_wdata, 32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      rst = 1'b0;

      // Single write from requester 0
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h3FF5_F000; wdata0 = 32'h8000_0001;
      tick();
      chk("wr_t_wr", 32'(t_wr), 32'd1);
      chk("wr_t_rd", 32'(t_rd), 32'd0);
      chk("wr_t_addr", t_addr, 32'h3FF5_F000);
      chk("wr_t_wdata", t_wdata, 32'h8000_0001);
      chk("wr_ack0_early", 32'(ack0), 32'd0);
      tick();
      chk("wr_ack0", 32'(ack0), 32'd1);
      chk("wr_err0", 32'(err0), 32'd0);
      chk("wr_t_wr_done", 32'(t_wr), 32'd0);
      chk("wr_ack1", 32'(ack1), 32'd0);
      req0 = 1'b0;
      tick();
      chk("wr_ack0_clear", 32'(ack0), 32'd0);

      // Single read from requester 1, timer answers one cycle after t_rd
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h3FF5_F000;
      tick();
      chk("rd_t_rd", 32'(t_rd), 32'd1);
      chk("rd_t_wr", 32'(t_wr), 32'd0);
      chk("rd_t_addr", t_addr, 32'h3FF5_F000);
      tick();
      t_rd_valid = 1'b1; t_rdata = 32'h8000_0001;
      chk("rd_t_rd_off", 32'(t_rd), 32'd0);
      chk("rd_t_addr_held", t_addr, 32'h3FF5_F000);
      chk("rd_ack1_early", 32'(ack1), 32'd0);
      tick();
      t_rd_valid = 1'b0; t_rdata = '0; req1 = 1'b0;
      chk("rd_ack1", 32'(ack1), 32'd1);
      chk("rd_rdata1", rdata1, 32'h8000_0001);
      chk("rd_err1", 32'(err1), 32'd0);
      chk("rd_ack0", 32'(ack0), 32'd0);
      tick();
      chk("rd_ack1_clear", 32'(ack1), 32'd0);

      // Contention right after reset: requester 0 first, then 1
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h3FF5_0010; wdata0 = 32'h0000_00A0;
      req1 = 1'b1; we1 = 1'b1; addr1 = 32'h3FF5_0020; wdata1 = 32'h0000_00B1;
      tick();
      chk("ct_first_wdata", t_wdata, 32'h0000_00A0);
      chk("ct_first_addr", t_addr, 32'h3FF5_0010);
      tick();
      chk("ct_first_ack0", 32'(ack0), 32'd1);
      chk("ct_first_ack1", 32'(ack1), 32'd0);
      req0 = 1'b0;
      tick();
      tick();
      chk("ct_second_wdata", t_wdata, 32'h0000_00B1);
      chk("ct_second_t_wr", 32'(t_wr), 32'd1);
      tick();
      chk("ct_second_ack1", 32'(ack1), 32'd1);
      chk("ct_second_ack0", 32'(ack0), 32'd0);
      req1 = 1'b0;
      tick();

      // Both held continuously: grants alternate 0,1,0,1
      req0 = 1'b1; req1 = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("alt_wdata", t_wdata, (k % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B1);
         tick();
         chk("alt_ack0", 32'(ack0), (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("alt_ack1", 32'(ack1), (k % 2 == 0) ? 32'd0 : 32'd1);
         tick();
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();

      // Out-of-window write: error ack at +1, no timer strobe
      req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4000_0000; wdata0 = 32'h1234_5678;
      tick();
      chk("oow_ack0", 32'(ack0), 32'd1);
      chk("oow_err0", 32'(err0), 32'd1);
      chk("oow_rdata0", rdata0, 32'd0);
      chk("oow_strobes", 32'({t_wr, t_rd}), 32'd0);
      chk("oow_t_wdata", t_wdata, 32'h0000_00B1);
      req0 = 1'b0;
      tick();
      chk("oow_ack0_clear", 32'(ack0), 32'd0);
      chk("oow_strobes2", 32'({t_wr, t_rd}), 32'd0);

      // Read timeout: ack with err 16 cycles after entering WAIT_RD
      req1 = 1'b1; we1 = 1'b0; addr1 = 32'h3FF5_0040;
      tick();
      chk("to_t_rd", 32'(t_rd), 32'd1);
      tick();
      acks_before = acks_seen;
      for (int i = 0; i < 15; i++)
         tick();
      chk("to_no_early_ack", 32'(acks_seen - acks_before), 32'd0);
      tick();
      chk("to_ack1", 32'(ack1), 32'd1);
      chk("to_err1", 32'(err1), 32'd1);
      chk("to_rdata1", rdata1, 32'd0);
      req1 = 1'b0;
      tick();
      chk("to_ack1_clear", 32'(ack1), 32'd0);
      t_rd_valid = 1'b1; t_rdata = 32'hCAFE_0001;
      tick();
      t_rd_valid = 1'b0;
      chk("stray_valid_ack", 32'({ack0, ack1}), 32'd0);
      tick();
      chk("stray_valid_ack2", 32'({ack0, ack1}), 32'd0);

      // Reset during WAIT_RD drops the read
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h3FF5_0008;
      tick();
      tick();
      tick();
      rst = 1'b1; req0 = 1'b0;
      tick();
      chk("mrst_acks", 32'({ack0, ack1}), 32'd0);
      chk("mrst_t_addr", t_addr, 32'd0);
      chk("mrst_t_wdata", t_wdata, 32'd0);
      chk("mrst_rdata1", rdata1, 32'd0);
      chk("mrst_strobes", 32'({t_wr, t_rd}), 32'd0);
      rst = 1'b0;
      acks_before = acks_seen;
      t_rd_valid = 1'b1; t_rdata = 32'h5555_AAAA;
      tick();
      t_rd_valid = 1'b0;
      tick();
      tick();
      chk("mrst_no_ack", 32'(acks_seen - acks_before), 32'd0);

      // Fresh read from requester 0 completes normally
      req0 = 1'b1; we0 = 1'b0; addr0 = 32'h3FF5_0004;
      tick();
      chk("fr_t_rd", 32'(t_rd), 32'd1);
      chk("fr_t_addr", t_addr, 32'h3FF5_0004);
      tick();
      t_rd_valid = 1'b1; t_rdata = 32'hDEAD_BEEF;
      tick();
      t_rd_valid = 1'b0; req0 = 1'b0;
      chk("fr_ack0", 32'(ack0), 32'd1);
      chk("fr_err0", 32'(err0), 32'd0);
      chk("fr_rdata0", rdata0, 32'hDEAD_BEEF);
      tick();
      chk("fr_ack0_clear", 32'(ack0), 32'd0);

      chk("exclusive_strobes_acks", 32'(excl_bad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
